// File: rtl/io_port_responder_if.sv
// io_port_responder_if: pin-side bundle of one 8-bit multiplexed I/O port.
// Ports: pin_stb/pin_we/pin_sel/pin_data_in driven by the initiator (CPU).
//        pin_data_out/pin_data_oe/pin_ack driven by the board-side responder.
interface io_port_responder_if;
    logic       pin_stb;
    logic       pin_we;
    logic [2:0] pin_sel;
    logic [7:0] pin_data_in;
    logic [7:0] pin_data_out;
    logic       pin_data_oe;
    logic       pin_ack;

    // CPU / initiator side
    modport master (
        output pin_stb, pin_we, pin_sel, pin_data_in,
        input  pin_data_out, pin_data_oe, pin_ack
    );

    // Board-side responder
    modport slave (
        input  pin_stb, pin_we, pin_sel, pin_data_in,
        output pin_data_out, pin_data_oe, pin_ack
    );
endinterface

// File: rtl/io_port_responder.sv
// io_port_responder: terminates the CPU four-phase port protocol and exposes 8 byte slots.
// Latency: strobe sample to ack = 1 edge direct, 3 edges with IDLE->EXEC->ACK behind the 2-flop sync.
// Backpressure: ack is held until the strobe drops; one operation per strobe, no merging of requests.
//
// Ports: clk, rst_n (async active-low); port (io_port_responder_if.slave: pin_stb, pin_we,
//        pin_sel, pin_data_in in; pin_data_out, pin_data_oe, pin_ack out);
//        slot_in[64] device bytes, slot_out[64] CPU-written bytes, slot_wr/slot_rd[8] one-hot pulses.
// Build option: define IO_RESP_SYNC_EN to synchronize the strobe for an asynchronous initiator.
module io_port_responder #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_port_responder_if.slave   port,
    input  logic [63:0]          slot_in,
    output logic [63:0]          slot_out,
    output logic [7:0]           slot_wr,
    output logic [7:0]           slot_rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_req_we;
    logic [2:0] r_req_sel;
    logic [7:0] r_req_data;
    logic [7:0] r_rd_reg;
    logic       r_ack;
    logic       r_oe;
    logic [63:0] r_slot_out;
    logic [7:0] r_slot_wr;
    logic [7:0] r_slot_rd;

    // Request as seen by the FSM after the input stage
    logic       w_stb_s;
    logic       w_we_s;
    logic [2:0] w_sel_s;
    logic [7:0] w_data_s;

`ifdef IO_RESP_SYNC_EN
    logic       r_stb_meta;
    logic       r_stb_sync;
    logic       r_we_q;
    logic [2:0] r_sel_q;
    logic [7:0] r_data_q;

    // Request fields get one register stage, taken at the same edge as the second strobe
    // flop; the initiator holds them stable until ack, so a single stage is sufficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_meta <= 1'b0;
            r_stb_sync <= 1'b0;
            r_we_q     <= 1'b0;
            r_sel_q    <= 3'd0;
            r_data_q   <= 8'h00;
        end else begin
            r_stb_meta <= port.pin_stb;
            r_stb_sync <= r_stb_meta;
            r_we_q     <= port.pin_we;
            r_sel_q    <= port.pin_sel;
            r_data_q   <= port.pin_data_in;
        end
    end

    assign w_stb_s  = r_stb_sync;
    assign w_we_s   = r_we_q;
    assign w_sel_s  = r_sel_q;
    assign w_data_s = r_data_q;
`else
    assign w_stb_s  = port.pin_stb;
    assign w_we_s   = port.pin_we;
    assign w_sel_s  = port.pin_sel;
    assign w_data_s = port.pin_data_in;
`endif

    // Bit offset of the selected slot within the 64-bit slot buses
    logic [5:0] w_lsb;
    assign w_lsb = {r_req_sel, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req_we   <= 1'b0;
            r_req_sel  <= 3'd0;
            r_req_data <= 8'h00;
            r_rd_reg   <= 8'h00;
            r_ack      <= 1'b0;
            r_oe       <= 1'b0;
            r_slot_out <= {8{RESET_VALUE}};
            r_slot_wr  <= 8'h00;
            r_slot_rd  <= 8'h00;
        end else begin
            // Slot strobes are single-cycle: only EXEC raises them
            r_slot_wr <= 8'h00;
            r_slot_rd <= 8'h00;
            case (r_state)
                ST_IDLE: begin
                    if (w_stb_s) begin
                        r_req_we   <= w_we_s;
                        r_req_sel  <= w_sel_s;
                        r_req_data <= w_data_s;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_req_we) begin
                        r_slot_out[w_lsb +: 8] <= r_req_data;
                        r_slot_wr              <= 8'b0000_0001 << r_req_sel;
                    end else begin
                        // rd_reg drives the pins directly and is frozen for the ACK phase
                        r_rd_reg  <= slot_in[w_lsb +: 8];
                        r_oe      <= 1'b1;
                        r_slot_rd <= 8'b0000_0001 << r_req_sel;
                    end
                    // Completes even if the strobe has already dropped; ACK then lasts one cycle
                    r_ack   <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    if (!w_stb_s) begin
                        r_ack    <= 1'b0;
                        r_oe     <= 1'b0;
                        r_rd_reg <= 8'h00;  // keeps pin_data_out at zero while the pad is off
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign port.pin_ack      = r_ack;
    assign port.pin_data_oe  = r_oe;
    assign port.pin_data_out = r_rd_reg;
    assign slot_out          = r_slot_out;
    assign slot_wr           = r_slot_wr;
    assign slot_rd           = r_slot_rd;

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed scoreboard bench for io_port_responder.
// Stimulus pushes the expected response of each operation; a monitor pops it at ack rise.
module tb_io_port_responder;

`ifdef IO_RESP_SYNC_EN
    localparam int LAT  = 3;   // edges after the sampling edge k until ack is high
    localparam int RLAT = 2;   // edges after the first edge sampling stb=0 until ack is low
`else
    localparam int LAT  = 1;
    localparam int RLAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] slot_in;
    logic [63:0] slot_out;
    logic [7:0]  slot_wr;
    logic [7:0]  slot_rd;

    io_port_responder_if pif();

    io_port_responder #(.RESET_VALUE(8'h00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port     (pif.slave),
        .slot_in  (slot_in),
        .slot_out (slot_out),
        .slot_wr  (slot_wr),
        .slot_rd  (slot_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [7:0]  wr;
        logic [7:0]  rd;
        logic        oe;
        logic [7:0]  dout;
        logic [63:0] sout;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          wr_cycles = 0;
    int          ack_rises = 0;
    logic [63:0] model_out = 64'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, compares at every ack rise
    logic       prev_ack = 1'b0;
    logic [7:0] prev_wr = 8'h00;
    logic [7:0] prev_rd = 8'h00;
    always @(negedge clk) begin
        if (pif.pin_ack && !prev_ack) begin
            ack_rises++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: ack rose with no expected op at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("slot_wr", {56'h0, slot_wr}, {56'h0, mon_e.wr});
                check("slot_rd", {56'h0, slot_rd}, {56'h0, mon_e.rd});
                check("data_oe", {63'h0, pif.pin_data_oe}, {63'h0, mon_e.oe});
                check("data_out", {56'h0, pif.pin_data_out}, {56'h0, mon_e.dout});
                check("slot_out", slot_out, mon_e.sout);
            end
        end
        if (prev_wr != 8'h00) check("wr_pulse_width", {56'h0, slot_wr}, 64'h0);
        if (prev_rd != 8'h00) check("rd_pulse_width", {56'h0, slot_rd}, 64'h0);
        if (!pif.pin_data_oe) check("dout_zero_oe_low", {56'h0, pif.pin_data_out}, 64'h0);
        if (slot_wr != 8'h00) wr_cycles++;
        prev_ack = pif.pin_ack;
        prev_wr  = slot_wr;
        prev_rd  = slot_rd;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request, queue its expected response and check ack latency
    task automatic start_op(input logic we, input logic [2:0] sel, input logic [7:0] data);
        exp_t e;
        int   s;
        int   n;
        s = int'(sel);
        pif.pin_we      = we;
        pif.pin_sel     = sel;
        pif.pin_data_in = data;
        if (we) model_out[s*8 +: 8] = data;
        e.we   = we;
        e.wr   = we ? 8'(1 << s) : 8'h00;
        e.rd   = we ? 8'h00 : 8'(1 << s);
        e.oe   = !we;
        e.dout = we ? 8'h00 : slot_in[s*8 +: 8];
        e.sout = model_out;
        sb.push_back(e);
        pif.pin_stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!pif.pin_ack && n < 30);
        check("ack_latency", 64'(n), 64'(LAT + 1));
    endtask

    // Hold the strobe, verify ack/read data persist, then release and check ack fall timing
    task automatic finish_op(input logic we, input logic [2:0] sel, input int hold);
        int         s;
        int         n;
        logic [7:0] rd_exp;
        s = int'(sel);
        rd_exp = slot_in[s*8 +: 8];
        if (!we) slot_in[s*8 +: 8] = 8'hFF;   // must not be reflected on the pins
        if (hold > 0) begin
            tick(hold);
            check("ack_held", {63'h0, pif.pin_ack}, 64'h1);
            if (!we) begin
                check("rd_freeze", {56'h0, pif.pin_data_out}, {56'h0, rd_exp});
                check("rd_oe_held", {63'h0, pif.pin_data_oe}, 64'h1);
            end else begin
                check("wr_oe_low", {63'h0, pif.pin_data_oe}, 64'h0);
            end
        end
        pif.pin_stb = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (pif.pin_ack && n < 30);
        check("ack_release", 64'(n), 64'(RLAT + 1));
    endtask

    task automatic do_op(input logic we, input logic [2:0] sel, input logic [7:0] data, input int hold);
        start_op(we, sel, data);
        finish_op(we, sel, hold);
    endtask

    int wr_before;
    int ack_before;
    int w;

    initial begin
        pif.pin_stb     = 1'b0;
        pif.pin_we      = 1'b0;
        pif.pin_sel     = 3'd0;
        pif.pin_data_in = 8'h00;
        slot_in         = 64'h8877_6655_443C_22E1;

        // Reset state
        tick(3);
        check("rst_ack", {63'h0, pif.pin_ack}, 64'h0);
        check("rst_oe", {63'h0, pif.pin_data_oe}, 64'h0);
        check("rst_slot_out", slot_out, 64'h0);
        check("rst_wr_rd", {48'h0, slot_wr, slot_rd}, 64'h0);
        rst_n = 1'b1;
        tick(2);

        // Write sel=5 A7
        wr_before = wr_cycles;
        do_op(1'b1, 3'd5, 8'hA7, 2);
        check("wr_slot5", {56'h0, slot_out[47:40]}, 64'hA7);
        check("wr_one_pulse", 64'(wr_cycles - wr_before), 64'd1);
        tick(1);

        // Read sel=2 with freeze after ack
        do_op(1'b0, 3'd2, 8'h00, 4);
        tick(1);

        // Long strobe: 20 cycles, one operation only
        wr_before = wr_cycles;
        do_op(1'b1, 3'd3, 8'h5A, 20);
        check("long_one_pulse", 64'(wr_cycles - wr_before), 64'd1);
        tick(1);

        // Back-to-back: read strobe re-raised right as ack falls
        ack_before = ack_rises;
        do_op(1'b1, 3'd0, 8'h11, 0);
        do_op(1'b0, 3'd0, 8'h00, 1);
        check("b2b_two_acks", 64'(ack_rises - ack_before), 64'd2);
        check("b2b_slot0", {56'h0, slot_out[7:0]}, 64'h11);
        tick(1);

        // Plain read of the top slot
        do_op(1'b0, 3'd7, 8'h00, 0);
        tick(1);

        // Early strobe drop: one cycle after sampling
        begin
            exp_t e;
            model_out[55:48] = 8'h96;
            e.we = 1'b1; e.wr = 8'b0100_0000; e.rd = 8'h00; e.oe = 1'b0;
            e.dout = 8'h00; e.sout = model_out;
            sb.push_back(e);
            pif.pin_we = 1'b1; pif.pin_sel = 3'd6; pif.pin_data_in = 8'h96;
            pif.pin_stb = 1'b1;
            tick(1);
            pif.pin_stb = 1'b0;
            w = 0;
            while (!pif.pin_ack && w < 30) begin
                tick(1);
                w++;
            end
            w = 0;
            while (pif.pin_ack && w < 30) begin
                tick(1);
                w++;
            end
            check("early_ack_width", 64'(w), 64'd1);
            check("early_slot6", {56'h0, slot_out[55:48]}, 64'h96);
        end
        tick(2);

        // Reset asserted mid-ACK
        start_op(1'b1, 3'd1, 8'h77);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ack", {63'h0, pif.pin_ack}, 64'h0);
        check("arst_oe", {63'h0, pif.pin_data_oe}, 64'h0);
        check("arst_slot_out", slot_out, 64'h0);
        check("arst_wr", {56'h0, slot_wr}, 64'h0);
        pif.pin_stb = 1'b0;
        model_out = 64'h0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Reset interrupting an operation before it completes: no pulse, no update
        wr_before = wr_cycles;
        pif.pin_we = 1'b1; pif.pin_sel = 3'd6; pif.pin_data_in = 8'h99;
        pif.pin_stb = 1'b1;
        tick(1);
        rst_n = 1'b0;
        pif.pin_stb = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("int_no_pulse", 64'(wr_cycles - wr_before), 64'd0);
        check("int_slot_out", slot_out, 64'h0);

        // FSM must be back in IDLE: normal latency again
        do_op(1'b1, 3'd4, 8'hC3, 1);
        check("post_rst_slot4", {56'h0, slot_out[39:32]}, 64'hC3);
        tick(3);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Board-side responder for one 8-bit multiplexed I/O port of the Rose Simple Computer. It terminates the CPU's port protocol: strobe, write-enable, 3-bit slot select, 8-bit data and acknowledge. It exposes eight byte-wide slots to local devices: eight output registers written by the CPU, and eight input bytes read by the CPU. Two instances, one per physical port, cover I/O addresses 0–7 and 8–15; the instance for addresses 8–15 receives `ioaddr[2:0]` as `pin_sel`.

## Interface
- `RESET_VALUE`, default `8'h00`: reset value loaded into every `slot_out` byte.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pin_stb` in 1: request strobe from the initiator, level-based, four-phase.
- `pin_we` in 1: 1 = write, 0 = read. Valid while `pin_stb` = 1.
- `pin_sel` in 3: slot select. Valid while `pin_stb` = 1.
- `pin_data_in` in 8: write data from the port pins. Valid while `pin_stb` = 1.
- `pin_data_out` out 8: read data toward the pins. Forced to `8'h00` when `pin_data_oe` = 0.
- `pin_data_oe` out 1: pad output enable.
- `pin_ack` out 1: acknowledge.
- `slot_in` in 64: device input bytes; byte i = bits `[8i+7:8i]`.
- `slot_out` out 64: CPU-written registers, same packing.
- `slot_wr` out 8: one-hot, one-cycle pulse on the slot just written.
- `slot_rd` out 8: one-hot, one-cycle pulse on the slot just read (device pop/clear).

## Operation
- **Input sampling.** `pin_stb`, `pin_we`, `pin_sel` and `pin_data_in` are seen through the input stage (see Configuration). The sampled strobe is called `stb_s`.
- **FSM states:** IDLE, EXEC, ACK.
  - **IDLE**: if `stb_s` = 1, capture we/sel/data into request registers, then go to EXEC.
  - **EXEC** (exactly 1 cycle):
    - Write: `slot_out[sel]` ← captured data, and `slot_wr[sel]` pulses.
    - Read: `rd_reg` ← `slot_in[sel]`, and `slot_rd[sel]` pulses.
    - Then go to ACK unconditionally.
  - **ACK**:
    - `pin_ack` = 1.
    - `pin_data_oe` = 1 only for reads, with `pin_data_out` = `rd_reg`.
    - Stay in ACK while `stb_s` = 1. When `stb_s` = 0, go to IDLE.
- **Outputs are registered.** `pin_ack`, `pin_data_oe`, `pin_data_out`, `slot_wr` and `slot_rd` are all flop outputs, with no combinational path from the pins.
- **Read data is frozen.** `rd_reg` is held for the whole ACK phase. Changes on `slot_in` after EXEC are not reflected.
- **Request fields are latched.** Changes to `pin_we`, `pin_sel` or `pin_data_in` after capture are ignored until the next IDLE capture.
- **Early strobe drop.** If `stb_s` falls during EXEC, the operation still completes and ACK lasts one cycle.
- **One operation per strobe.** A strobe held high indefinitely yields exactly one operation; `pin_ack` stays high until it drops.
- **Back-to-back requests.** `stb_s` re-asserted in the same cycle the FSM returns to IDLE is accepted on the next edge. A new request is never merged into the previous one.
- **Reset** (asynchronous, any state, including mid-operation):
  - FSM goes to IDLE.
  - `pin_ack` = 0, `pin_data_oe` = 0, `pin_data_out` = `8'h00`.
  - `slot_wr` = 0, `slot_rd` = 0.
  - Every `slot_out` byte = `RESET_VALUE`.
  - `rd_reg` and the request registers = 0.
  - Synchronizer flops = 0.
  - No `slot_wr`/`slot_rd` pulse is emitted for an interrupted operation.

## Timing
- Let k = the first rising edge at which `pin_stb` = 1 is sampled.
- **With `IO_RESP_SYNC_EN`:**
  - `stb_s` = 1 after edge k+1.
  - EXEC is entered at edge k+2.
  - `slot_wr`/`slot_rd` are high for the cycle after edge k+3.
  - `slot_out` is updated at edge k+3.
  - `pin_ack` and `pin_data_oe` rise after edge k+3.
- **Without `IO_RESP_SYNC_EN`:** EXEC at edge k, update and `pin_ack` at edge k+1.
- **Release:** `pin_ack` and `pin_data_oe` fall 2 edges (sync) or 0 edges (direct) after the edge that first samples `pin_stb` = 0, i.e. one edge after `stb_s` = 0 is seen in ACK.
- **Minimum cycle time:** 3 cycles plus synchronizer latency on each edge of the strobe.

## Configuration
- **`IO_RESP_SYNC_EN` defined:**
  - `pin_stb` passes through a 2-flop synchronizer.
  - `pin_we`, `pin_sel` and `pin_data_in` are captured from a single register stage taken at the same edge as the second `stb` flop. They must be stable from `pin_stb` rise until `pin_ack` rise.
  - Safe for an asynchronous initiator.
- **Undefined:** all pins are used directly; the initiator must be synchronous to `clk`.

## Test plan
- **Reset values:** reset asserted mid-ACK → `pin_ack` = 0 and `pin_data_oe` = 0 immediately (asynchronous); all `slot_out` bytes = `8'h00`; FSM in IDLE; no `slot_wr` pulse.
- **Write:** write sel=5, data=`8'hA7` → `slot_out[47:40]` = `8'hA7`; `slot_wr` = `8'b0010_0000` for exactly one cycle; `pin_ack` rises at k+3 (sync) or k+1 (direct); `pin_data_oe` stays 0.
- **Read freeze:** read sel=2 with `slot_in[23:16]` = `8'h3C`, changed to `8'hFF` during ACK → `pin_data_out` holds `8'h3C` and `pin_data_oe` = 1 until ack drops; `slot_rd` = `8'b0000_0100` for one pulse.
- **Long strobe:** `pin_stb` held high for 20 cycles → exactly one `slot_wr` pulse; `pin_ack` high until 2 edges after stb falls.
- **Back-to-back:** write sel=0 `8'h11`, then read sel=0 with `pin_stb` re-raised on the cycle ack falls → `slot_out[7:0]` = `8'h11`; the read returns `slot_in[7:0]`; two distinct ack pulses.
- **Early strobe drop:** `pin_stb` dropped one cycle after sampling (direct mode) → write still completes; `pin_ack` high for exactly one cycle.
